hamming_serial_encoder: RTL and testbench

- Parametrised Hamming serial line encoder: accepts a DATA_W-bit word over a valid/ready handshake and emits one bit per clk.
- Frame order: start bit, data bits, Hamming parity bits, optional overall (SECDED) parity bit.
- Sits between the source data path and the channel/modulator stage; feeds the matching serial Hamming decoder.
- Adds a handshake, back-to-back framing, configurable code size and idle/start levels.

---
 rtl/hamming_serial_encoder.sv | 135 +++++++++++++
 tb/tb_hamming_serial_encoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_encoder.sv
// Serial Hamming line encoder. Each accepted word goes out as a frame:
// start bit, data bits (LSB first), Hamming parity bits (p0 first), and an
// optional overall even-parity bit.
module hamming_serial_encoder #(
    parameter int unsigned DATA_W    = 4,
    parameter bit          EXT_PAR   = 1'b0,
    parameter bit          START_LVL = 1'b1,
    parameter bit          IDLE_LVL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              sof
);

    localparam int unsigned PAR_W     = (DATA_W == 4)  ? 3 :
                                        (DATA_W == 11) ? 4 :
                                        (DATA_W == 26) ? 5 : 1;
    localparam int unsigned FRAME_LEN = 1 + DATA_W + PAR_W + (EXT_PAR ? 1 : 0);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    // Frame vector padded to the full index range so any idx value selects a real bit.
    localparam int unsigned FRAME_PAD = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    if (DATA_W != 4 && DATA_W != 11 && DATA_W != 26) begin : g_bad_data_w
        $error("hamming_serial_encoder: DATA_W must be 4, 11 or 26");
    end

    // Bit i of the result is set when data bit i sits at a Hamming position with bit j set.
    // Data positions are the non-powers-of-two in ascending order: 3, 5, 6, 7, 9, ...
    function automatic logic [DATA_W-1:0] par_mask(input int j);
        logic [DATA_W-1:0] m;
        int                pos;
        m   = '0;
        pos = 1;
        for (int i = 0; i < DATA_W; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            m[i] = (((pos >> j) & 1) != 0);
        end
        return m;
    endfunction

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_W-1:0]    r_data, w_data_nxt;
    logic                 r_out, w_out_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_sof, w_sof_nxt;

    logic [PAR_W-1:0]     w_par;
    logic [FRAME_PAD-1:0] w_frame;
    logic [IDX_W-1:0]     w_idx_inc;
    logic                 w_last;
    logic                 w_accept;

    for (genvar j = 0; j < PAR_W; j++) begin : g_par
        localparam logic [DATA_W-1:0] MASK = par_mask(j);
        assign w_par[j] = ^(r_data & MASK);
    end

    // Assemble the whole frame from the latched word; idx selects the bit on the line.
    always_comb begin
        w_frame                          = '0;
        w_frame[0]                       = START_LVL;
        w_frame[DATA_W:1]                = r_data;
        w_frame[DATA_W+PAR_W:DATA_W+1]   = w_par;
        if (EXT_PAR) begin
            w_frame[FRAME_LEN-1] = ^{r_data, w_par};
        end
    end

    assign w_idx_inc = r_idx + 1'b1;
    assign w_last    = (r_state == StSend) && (r_idx == LAST_IDX);
    assign in_ready  = !rst && ((r_state == StIdle) || w_last);
    assign w_accept  = in_valid && in_ready;

    // Next-state and next-output logic: accept a word, step through the frame, or idle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_out_nxt   = IDLE_LVL;
        w_busy_nxt  = 1'b0;
        w_sof_nxt   = 1'b0;
        if (w_accept) begin
            w_state_nxt = StSend;
            w_idx_nxt   = '0;
            w_data_nxt  = in_data;
            w_out_nxt   = START_LVL;
            w_busy_nxt  = 1'b1;
            w_sof_nxt   = 1'b1;
        end else if (r_state == StSend && !w_last) begin
            w_idx_nxt  = w_idx_inc;
            w_out_nxt  = w_frame[w_idx_inc];
            w_busy_nxt = 1'b1;
        end else begin
            w_state_nxt = StIdle;
            w_idx_nxt   = '0;
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_data  <= '0;
            r_out   <= IDLE_LVL;
            r_busy  <= 1'b0;
            r_sof   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_sof   <= w_sof_nxt;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign sof  = r_sof;

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Directed bench for the serial Hamming encoder: a 4-bit SECDED instance and
// an 11-bit instance without the overall parity bit.
module tb_hamming_serial_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a_data  = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_out, a_busy, a_sof;

    logic [10:0] b_data  = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_out, b_busy, b_sof;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hamming_serial_encoder #(
        .DATA_W    (4),
        .EXT_PAR   (1'b1),
        .START_LVL (1'b1),
        .IDLE_LVL  (1'b0)
    ) u_enc4 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (a_data),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .out      (a_out),
        .busy     (a_busy),
        .sof      (a_sof)
    );

    hamming_serial_encoder #(
        .DATA_W    (11),
        .EXT_PAR   (1'b0),
        .START_LVL (1'b1),
        .IDLE_LVL  (1'b0)
    ) u_enc11 (
        .clk      (clk),
        .rst      (rst),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .out      (b_out),
        .busy     (b_busy),
        .sof      (b_sof)
    );

    // Frame bits written in line order: leftmost literal bit goes out first.
    typedef struct {
        logic [3:0] data;
        logic [8:0] seq;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [cycle %0d]: got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the 4-bit instance for one frame cycle k, with an optional follow-on frame.
    task automatic chk_a_bit(input int k, input logic exp_bit, input bit first, input bit last);
        chk("a_out", k, a_out, exp_bit);
        chk("a_busy", k, a_busy, 1'b1);
        chk("a_sof", k, a_sof, first);
        chk("a_ready", k, a_ready, last);
    endtask

    task automatic send4(input logic [3:0] d, input logic [8:0] seq);
        a_data  = d;
        a_valid = 1'b1;
        chk("a_ready_idle", -1, a_ready, 1'b1);
        step();
        a_valid = 1'b0;
        a_data  = ~d;
        for (int k = 0; k < 9; k++) begin
            chk_a_bit(k, seq[8-k], k == 0, k == 8);
            if (k < 8) step();
        end
        step();
        chk("a_out_after", 9, a_out, 1'b0);
        chk("a_busy_after", 9, a_busy, 1'b0);
        chk("a_ready_after", 9, a_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] b_seq;
        logic [17:0] bb_seq;

        vecs[0] = '{data: 4'b1011, seq: 9'b111011000};
        vecs[1] = '{data: 4'b1111, seq: 9'b111111111};
        vecs[2] = '{data: 4'b0000, seq: 9'b100000000};
        vecs[3] = '{data: 4'b0001, seq: 9'b110001101};
        vecs[4] = '{data: 4'b0110, seq: 9'b101101100};

        // Reset for two cycles with no valid input
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_a_out", 0, a_out, 1'b0);
        chk("rst_a_busy", 0, a_busy, 1'b0);
        chk("rst_a_sof", 0, a_sof, 1'b0);
        chk("rst_a_ready", 0, a_ready, 1'b1);
        chk("rst_b_out", 0, b_out, 1'b0);
        chk("rst_b_busy", 0, b_busy, 1'b0);
        chk("rst_b_ready", 0, b_ready, 1'b1);
        step();
        chk("idle_a_out", 1, a_out, 1'b0);
        chk("idle_a_busy", 1, a_busy, 1'b0);

        // Single frames from the vector table
        for (int v = 0; v < 5; v++) begin
            send4(vecs[v].data, vecs[v].seq);
            step();
        end

        // Back-to-back: 1011 then 1111 with valid held high
        bb_seq  = {9'b111011000, 9'b111111111};
        a_data  = 4'b1011;
        a_valid = 1'b1;
        chk("bb_ready_idle", -1, a_ready, 1'b1);
        step();
        a_data = 4'b1111;
        for (int k = 0; k < 18; k++) begin
            chk_a_bit(k, bb_seq[17-k], (k == 0) || (k == 9), (k == 8) || (k == 17));
            if (k == 9) a_valid = 1'b0;
            if (k < 17) step();
        end
        step();
        chk("bb_out_after", 18, a_out, 1'b0);
        chk("bb_busy_after", 18, a_busy, 1'b0);
        step();

        // 11-bit frame, word flipped right after acceptance
        b_seq   = 16'b1100000000001100;
        b_data  = 11'h001;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        b_data  = 11'h7FF;
        for (int k = 0; k < 16; k++) begin
            chk("b_out", k, b_out, b_seq[15-k]);
            chk("b_busy", k, b_busy, 1'b1);
            chk("b_sof", k, b_sof, k == 0);
            chk("b_ready", k, b_ready, k == 15);
            if (k < 15) step();
        end
        step();
        chk("b_out_after", 16, b_out, 1'b0);
        chk("b_busy_after", 16, b_busy, 1'b0);
        step();

        // Reset mid-frame at idx 4, then a clean frame
        a_data  = 4'b1111;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_a_out_idx4", 4, a_out, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_ready_in_rst", 4, a_ready, 1'b0);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("mid_a_out", 5, a_out, 1'b0);
        chk("mid_a_busy", 5, a_busy, 1'b0);
        chk("mid_a_sof", 5, a_sof, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after", 5, a_ready, 1'b1);
        step();
        chk("mid_idle_out", 6, a_out, 1'b0);
        chk("mid_idle_busy", 6, a_busy, 1'b0);
        send4(4'b1011, 9'b111011000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
